// File: rtl/alu_serial_addsub_ctrl_pkg.sv
// Shared definitions for the serial add/subtract sequencer: FSM encodings,
// slice width and the single-bit full adder the slice is built from.
package alu_serial_addsub_ctrl_pkg;

    localparam int SLICE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Returns {carry_out, sum} for one bit position.
    function automatic logic [1:0] full_adder(input logic a, input logic b, input logic cin);
        return {(a & b) | (cin & (a ^ b)), a ^ b ^ cin};
    endfunction

endpackage

// File: rtl/alu_serial_addsub_ctrl_if.sv
// Operand request / result writeback bundle between the ALU front-end,
// the serial add/subtract controller and the writeback stage.
interface alu_serial_addsub_ctrl_if #(parameter int WIDTH = 16);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_carry;
    logic             out_ovf;
    logic             out_zero;
    logic             busy;

    modport master (
        output in_valid, in_a, in_b, in_sub, out_ready,
        input  in_ready, out_valid, out_result, out_carry, out_ovf, out_zero, busy
    );

    modport slave (
        input  in_valid, in_a, in_b, in_sub, out_ready,
        output in_ready, out_valid, out_result, out_carry, out_ovf, out_zero, busy
    );

endinterface

// File: rtl/alu_serial_addsub_ctrl_slice.sv
// 4-bit ripple-carry slice; exposes the carries out of bits 3 and 2 so the
// controller can derive signed overflow on the final nibble.
module alu_slice4_ovf
    import alu_serial_addsub_ctrl_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    output logic [SLICE_W-1:0] sum,
    output logic [1:0]         carry
);

    logic [SLICE_W:0] c;
    logic [1:0]       fa;

    always_comb begin
        c    = '0;
        sum  = '0;
        fa   = '0;
        c[0] = cin;
        for (int i = 0; i < SLICE_W; i++) begin
            fa       = full_adder(a[i], b[i], c[i]);
            sum[i]   = fa[0];
            c[i+1]   = fa[1];
        end
        carry = {c[SLICE_W], c[SLICE_W-1]};
    end

endmodule

// File: rtl/alu_serial_addsub_ctrl.sv
// Runs a WIDTH-bit add/subtract through one shared 4-bit slice, one nibble per cycle.
// Define ALU_SAT_EN to saturate the result on signed overflow.
module alu_serial_addsub_ctrl
    import alu_serial_addsub_ctrl_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    alu_serial_addsub_ctrl_if.slave bus
);

    localparam int NSL   = WIDTH / SLICE_W;
    localparam int IDX_W = (NSL > 1) ? $clog2(NSL) : 1;

    state_t             state;
    state_t             state_next;
    logic               accept;
    logic               last;

    logic [IDX_W-1:0]   idx;
    logic               carry_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   res_q;
    logic               carry_out_q;
    logic               ovf_q;
    logic               zero_q;

    logic [SLICE_W-1:0] a_nib;
    logic [SLICE_W-1:0] b_nib;
    logic [SLICE_W-1:0] sum_nib;
    logic [1:0]         slice_c;
    logic               ovf_now;
    logic [WIDTH-1:0]   res_next;
    logic [WIDTH-1:0]   res_final;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next     = state;
        accept         = 1'b0;
        last           = 1'b0;
        bus.in_ready   = 1'b0;
        bus.out_valid  = 1'b0;
        bus.busy       = 1'b0;
        case (state)
            ST_IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    accept     = 1'b1;
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                bus.busy = 1'b1;
                if (idx == IDX_W'(NSL - 1)) begin
                    last       = 1'b1;
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                bus.busy      = 1'b1;
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    alu_slice4_ovf u_slice (
        .a     (a_nib),
        .b     (b_nib),
        .cin   (carry_q),
        .sum   (sum_nib),
        .carry (slice_c)
    );

    // The slice output is merged into the current nibble; on the last pass this
    // merged word is the full result, optionally replaced by the saturation value.
    always_comb begin
        a_nib    = a_q[idx*SLICE_W +: SLICE_W];
        b_nib    = b_q[idx*SLICE_W +: SLICE_W];
        ovf_now  = slice_c[1] ^ slice_c[0];
        res_next = res_q;
        res_next[idx*SLICE_W +: SLICE_W] = sum_nib;
        res_final = res_next;
`ifdef ALU_SAT_EN
        if (ovf_now) begin
            res_final = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx         <= '0;
            carry_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            carry_out_q <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
        end else if (accept) begin
            // Subtraction is A + ~B + 1, so the inverted B and the initial carry are latched here.
            a_q         <= bus.in_a;
            b_q         <= bus.in_sub ? ~bus.in_b : bus.in_b;
            carry_q     <= bus.in_sub;
            idx         <= '0;
            res_q       <= '0;
            carry_out_q <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
        end else if (state == ST_RUN) begin
            carry_q <= slice_c[1];
            idx     <= idx + 1'b1;
            if (last) begin
                res_q       <= res_final;
                carry_out_q <= slice_c[1];
                ovf_q       <= ovf_now;
                zero_q      <= (res_final == '0);
            end else begin
                res_q <= res_next;
            end
        end
    end

    assign bus.out_result = res_q;
    assign bus.out_carry  = carry_out_q;
    assign bus.out_ovf    = ovf_q;
    assign bus.out_zero   = zero_q;

endmodule

// File: tb/tb_alu_serial_addsub_ctrl.sv
// Scoreboard bench for alu_serial_addsub_ctrl (WIDTH=16); expected results come
// from a wide-add reference model and are queued at request time.
module tb_alu_serial_addsub_ctrl;

    localparam int WIDTH = 16;
    localparam int NSL   = WIDTH / 4;

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic             carry;
        logic             ovf;
        logic             zero;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   tests_run = 0;
    int   tests_failed = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    alu_serial_addsub_ctrl_if #(.WIDTH(WIDTH)) bus ();

    alu_serial_addsub_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Reference: one wide addition, overflow from operand/result signs.
    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic sub);
        exp_t             r;
        logic [WIDTH-1:0] bb;
        logic [WIDTH:0]   full;
        bb       = sub ? ~b : b;
        full     = {1'b0, a} + {1'b0, bb} + (WIDTH+1)'(sub);
        r.carry  = full[WIDTH];
        r.result = full[WIDTH-1:0];
        r.ovf    = (a[WIDTH-1] == bb[WIDTH-1]) && (full[WIDTH-1] != a[WIDTH-1]);
`ifdef ALU_SAT_EN
        if (r.ovf) r.result = a[WIDTH-1] ? 16'h8000 : 16'h7FFF;
`endif
        r.zero   = (r.result == '0);
        return r;
    endfunction

    function automatic exp_t observed();
        return {bus.out_result, bus.out_carry, bus.out_ovf, bus.out_zero};
    endfunction

    task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic sub);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_sub   = sub;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int cycles);
        cycles = 0;
        while (bus.out_valid !== 1'b1 && cycles < 40) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic release_result();
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_sub    = 1'b0;
        bus.out_ready = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        tests_run++;
        if ({bus.in_ready, bus.out_valid, bus.busy, observed()} !== {3'b100, 19'd0}) begin
            tests_failed++;
            $display("[TB] FAIL reset_outputs: got rdy=%b val=%b busy=%b res=%h c=%b o=%b z=%b, want rdy=1 rest 0",
                     bus.in_ready, bus.out_valid, bus.busy, bus.out_result, bus.out_carry, bus.out_ovf, bus.out_zero);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_vectors();
        logic [WIDTH-1:0] ta[6] = '{16'h7FFF, 16'h0005, 16'hFFFF, 16'h8000, 16'hA5A5, 16'h0000};
        logic [WIDTH-1:0] tb[6] = '{16'h0001, 16'h0005, 16'h0001, 16'h0001, 16'h5A5B, 16'h0001};
        logic             ts[6] = '{1'b0,     1'b1,     1'b0,     1'b1,     1'b0,     1'b1};
        exp_t e;
        int   cyc;
        for (int i = 0; i < 6; i++) begin
            send(ta[i], tb[i], ts[i]);
            sb.push_back(model(ta[i], tb[i], ts[i]));
            wait_valid(cyc);
            e = sb.pop_front();
            tests_run++;
            if (cyc !== NSL) begin
                tests_failed++;
                $display("[TB] FAIL latency[%0d]: got %0d cycles, want %0d", i, cyc, NSL);
            end
            tests_run++;
            if (observed() !== e) begin
                tests_failed++;
                $display("[TB] FAIL result[%0d] %h %s %h: got res=%h c=%b o=%b z=%b, want res=%h c=%b o=%b z=%b",
                         i, ta[i], ts[i] ? "-" : "+", tb[i], bus.out_result, bus.out_carry, bus.out_ovf,
                         bus.out_zero, e.result, e.carry, e.ovf, e.zero);
            end
            release_result();
        end
    endtask

    task automatic test_backpressure();
        exp_t e;
        int   cyc;
        send(16'h4000, 16'h4000, 1'b0);
        sb.push_back(model(16'h4000, 16'h4000, 1'b0));
        wait_valid(cyc);
        e = sb.pop_front();
        for (int k = 0; k < 5; k++) begin
            bus.in_valid = k[0];
            bus.in_a     = 16'h0101;
            bus.in_b     = 16'h0202;
            @(negedge clk);
            tests_run++;
            if ({bus.out_valid, bus.in_ready, observed()} !== {2'b10, e}) begin
                tests_failed++;
                $display("[TB] FAIL hold[%0d]: got val=%b rdy=%b res=%h c=%b o=%b z=%b, want val=1 rdy=0 res=%h c=%b o=%b z=%b",
                         k, bus.out_valid, bus.in_ready, bus.out_result, bus.out_carry, bus.out_ovf, bus.out_zero,
                         e.result, e.carry, e.ovf, e.zero);
            end
        end
        bus.in_valid = 1'b0;
        release_result();
        tests_run++;
        if ({bus.in_ready, bus.out_valid, bus.busy} !== 3'b100) begin
            tests_failed++;
            $display("[TB] FAIL idle_after_release: got rdy=%b val=%b busy=%b, want 1 0 0",
                     bus.in_ready, bus.out_valid, bus.busy);
        end
    endtask

    task automatic test_reset_mid_run();
        exp_t e;
        int   cyc;
        int   seen = 0;
        send(16'hF0F0, 16'h0F0F, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if ({bus.in_ready, bus.out_valid, bus.busy, observed()} !== {3'b100, 19'd0}) begin
            tests_failed++;
            $display("[TB] FAIL mid_run_reset: got rdy=%b val=%b busy=%b res=%h c=%b o=%b z=%b, want rdy=1 rest 0",
                     bus.in_ready, bus.out_valid, bus.busy, bus.out_result, bus.out_carry, bus.out_ovf, bus.out_zero);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) seen++;
        end
        tests_run++;
        if (seen !== 0) begin
            tests_failed++;
            $display("[TB] FAIL discarded_result: got %0d valid cycles, want 0", seen);
        end
        send(16'h1234, 16'h1111, 1'b0);
        sb.push_back(model(16'h1234, 16'h1111, 1'b0));
        wait_valid(cyc);
        e = sb.pop_front();
        tests_run++;
        if (bus.out_valid !== 1'b1 || bus.out_result !== 16'h2345 || observed() !== e) begin
            tests_failed++;
            $display("[TB] FAIL after_reset_op: got val=%b res=%h, want val=1 res=2345", bus.out_valid, bus.out_result);
        end
        release_result();
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             s;
        exp_t             e;
        int               cyc;
        for (int i = 0; i < 10; i++) begin
            a = WIDTH'($urandom);
            b = WIDTH'($urandom);
            s = 1'($urandom_range(0, 1));
            send(a, b, s);
            sb.push_back(model(a, b, s));
            wait_valid(cyc);
            e = sb.pop_front();
            tests_run++;
            if (bus.out_valid !== 1'b1 || observed() !== e) begin
                tests_failed++;
                $display("[TB] FAIL b2b[%0d] %h %s %h: got val=%b res=%h c=%b o=%b z=%b, want res=%h c=%b o=%b z=%b",
                         i, a, s ? "-" : "+", b, bus.out_valid, bus.out_result, bus.out_carry, bus.out_ovf,
                         bus.out_zero, e.result, e.carry, e.ovf, e.zero);
            end
            release_result();
        end
        tests_run++;
        if (sb.size() !== 0) begin
            tests_failed++;
            $display("[TB] FAIL scoreboard_empty: got %0d left, want 0", sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
